rab_intc: RTL and testbench

- RAB-attached interrupt controller for the MCU subsystem.
- Collects 8 hardware event sources, synchronises them, and latches them into pending bits.
- Applies per-source mask and a global enable, then drives the single interrupt request net ex0 that feeds the R80515 int0 input.
- Sits directly upstream of the CPU interrupt input. It is a slave on the arbitrated RAB bus (rab_write/rab_read/rab_addr/rab_wdata/rab_ack/rab_rdata), alongside the I2C master and register file.

---
 rtl/rab_intc.sv | 166 ++++++++++++++++
 tb/tb_rab_intc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rab_intc.sv
// RAB-slave interrupt controller: 8 synchronised sources latched into pending bits, masked and merged onto ex0.
// Define INTC_SYNC3_EN for a 3-flop source synchroniser (one extra cycle of latency); default is 2 flops.
module rab_intc #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NSRC   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [4:0]        baseaddr,
  input  logic              rab_write,
  input  logic              rab_read,
  input  logic [ADDR_W-1:0] rab_addr,
  input  logic [DATA_W-1:0] rab_wdata,
  output logic              rab_ack,
  output logic [DATA_W-1:0] rab_rdata,
  input  logic [NSRC-1:0]   irq_src,
  output logic              ex0
);

`ifdef INTC_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_RAW    = 3'd3;
  localparam logic [2:0] OFF_SET    = 3'd4;
  localparam logic [2:0] OFF_ID     = 3'd5;
  localparam logic [2:0] OFF_CTRL   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  bus_state_e        state_q, state_d;
  logic [NSRC-1:0]   sync_q [SYNC_STAGES];
  logic [NSRC-1:0]   sync_src, sync_src_d_q;
  logic [NSRC-1:0]   status_q, status_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [NSRC-1:0]   edge_q, edge_d;
  logic              en_q, en_d;
  logic              ex0_q, ex0_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req, hit, take, wr_take, rd_take;
  logic [2:0]        offset;
  logic [NSRC-1:0]   pend_set, pend_clr, sw_set, pend_masked;
  logic [DATA_W-1:0] rd_mux, id_val;
  logic              unused_addr;

  assign sync_src    = sync_q[SYNC_STAGES-1];
  assign req         = rab_write | rab_read;
  assign hit         = (rab_addr[ADDR_W-1 -: 5] == baseaddr);
  assign offset      = rab_addr[2:0];
  assign unused_addr = ^rab_addr[ADDR_W-6:3];
  assign pend_masked = status_q & mask_q;

  // Bus FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Bus FSM: next state; a held request parks in WAIT so it is acked only once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req && hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus FSM: outputs; write has priority over read when both are raised
  always_comb begin
    take    = (state_q == ST_IDLE) && req && hit;
    wr_take = take && rab_write;
    rd_take = take && rab_read && !rab_write;
  end

  // Fixed priority: bit 0 wins
  always_comb begin
    id_val = 8'hFF;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (pend_masked[i]) id_val = DATA_W'(i);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_STATUS: rd_mux = status_q;
      OFF_MASK:   rd_mux = mask_q;
      OFF_EDGE:   rd_mux = edge_q;
      OFF_RAW:    rd_mux = sync_src;
      OFF_ID:     rd_mux = id_val;
      OFF_CTRL:   rd_mux = {{(DATA_W-1){1'b0}}, en_q};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    pend_clr = '0;
    sw_set   = '0;
    mask_d   = mask_q;
    edge_d   = edge_q;
    en_d     = en_q;
    if (wr_take) begin
      case (offset)
        OFF_STATUS: pend_clr = rab_wdata;
        OFF_MASK:   mask_d   = rab_wdata;
        OFF_EDGE:   edge_d   = rab_wdata;
        OFF_SET:    sw_set   = rab_wdata;
        OFF_CTRL:   en_d     = rab_wdata[0];
        default:    ;
      endcase
    end
  end

  // Set beats clear on the same bit in the same cycle
  always_comb begin
    pend_set = (edge_q & sync_src & ~sync_src_d_q) | (~edge_q & sync_src) | sw_set;
    status_d = (status_q & ~pend_clr) | pend_set;
    ex0_d    = en_q & (|pend_masked);
    ack_d    = take;
    rdata_d  = rd_take ? rd_mux : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_src_d_q <= '0;
      status_q     <= '0;
      mask_q       <= '0;
      edge_q       <= '1;
      en_q         <= 1'b0;
      ex0_q        <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_src_d_q <= sync_src;
      status_q     <= status_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      en_q         <= en_d;
      ex0_q        <= ex0_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rab_ack   = ack_q;
  assign rab_rdata = rdata_q;
  assign ex0       = ex0_q;

endmodule

// File: tb/tb_rab_intc.sv
// Bench for rab_intc: cycle-level reference model plus directed register/latency scenarios.
module tb_rab_intc;
`ifdef INTC_SYNC3_EN
  localparam int NS = 3;
`else
  localparam int NS = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  baseaddr = 5'h3;
  logic        rab_write = 1'b0, rab_read = 1'b0;
  logic [15:0] rab_addr = '0;
  logic [7:0]  rab_wdata = '0;
  logic        rab_ack;
  logic [7:0]  rab_rdata;
  logic [7:0]  irq_src = 8'hFF;
  logic        ex0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rab_intc dut (
    .sys_clk(clk), .sys_rst(rst_n), .baseaddr(baseaddr),
    .rab_write(rab_write), .rab_read(rab_read), .rab_addr(rab_addr),
    .rab_wdata(rab_wdata), .rab_ack(rab_ack), .rab_rdata(rab_rdata),
    .irq_src(irq_src), .ex0(ex0)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lowest_id(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(i);
    return 8'hFF;
  endfunction

  function automatic logic [15:0] ra(input logic [2:0] off);
    return {5'h3, 8'h00, off};
  endfunction

  // Reference model: pending bits, registers, bus response and a sampled history of irq_src
  logic [7:0] m_status, m_mask, m_edge, m_ctrl, m_rdata;
  logic       m_ex0, m_ack, m_busy;
  logic [7:0] hist [4];
  logic [7:0] mv_sync, mv_syncd, mv_set, mv_clr, mv_rd;
  logic       mv_req, mv_take, mv_ex0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_status = 0; m_mask = 0; m_edge = 8'hFF; m_ctrl = 0;
      m_ex0 = 0; m_ack = 0; m_rdata = 0; m_busy = 0;
      for (int k = 0; k < 4; k++) hist[k] = 0;
    end else begin
      mv_sync  = hist[NS-1];
      mv_syncd = hist[NS];
      mv_set   = (m_edge & mv_sync & ~mv_syncd) | (~m_edge & mv_sync);
      mv_clr   = 0;
      mv_rd    = 0;
      mv_ex0   = m_ctrl[0] && ((m_status & m_mask) != 0);
      mv_req   = rab_write | rab_read;
      mv_take  = !m_busy && mv_req && (rab_addr[15:11] == baseaddr);
      if (mv_take) begin
        if (rab_write) begin
          case (rab_addr[2:0])
            3'd0: mv_clr = rab_wdata;
            3'd1: m_mask = rab_wdata;
            3'd2: m_edge = rab_wdata;
            3'd4: mv_set = mv_set | rab_wdata;
            3'd6: m_ctrl = {7'b0, rab_wdata[0]};
            default: ;
          endcase
        end else begin
          case (rab_addr[2:0])
            3'd0: mv_rd = m_status;
            3'd1: mv_rd = m_mask;
            3'd2: mv_rd = m_edge;
            3'd3: mv_rd = mv_sync;
            3'd5: mv_rd = lowest_id(m_status & m_mask);
            3'd6: mv_rd = m_ctrl;
            default: mv_rd = 0;
          endcase
        end
      end
      m_busy   = mv_take ? 1'b1 : (mv_req ? m_busy : 1'b0);
      m_status = (m_status & ~mv_clr) | mv_set;
      m_ex0    = mv_ex0;
      m_ack    = mv_take;
      m_rdata  = mv_rd;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_src;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_ex0", {7'b0, ex0}, {7'b0, m_ex0});
    chk("model_ack", {7'b0, rab_ack}, {7'b0, m_ack});
    chk("model_rdata", rab_rdata, m_rdata);
  end

  task automatic bus(input logic wr, input logic rd, input logic [15:0] addr,
                     input logic [7:0] wd, output logic [7:0] rdo);
    bit got = 0;
    rdo = 8'hXX;
    @(negedge clk);
    rab_write = wr; rab_read = rd; rab_addr = addr; rab_wdata = wd;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (rab_ack) begin got = 1; rdo = rab_rdata; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL bus_timeout: no ack for addr %04h", addr);
    end
    @(negedge clk);
    rab_write = 0; rab_read = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] v);
    logic [7:0] d;
    bus(1'b1, 1'b0, ra(off), v, d);
  endtask

  task automatic rd_check(input string name, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] d;
    bus(1'b0, 1'b1, ra(off), 8'h00, d);
    chk(name, d, exp);
  endtask

  initial begin
    int acks;
    logic [7:0] d;
    // Reset with all sources high
    repeat (3) @(negedge clk);
    chk("rst_ex0", {7'b0, ex0}, 8'h00);
    chk("rst_ack", {7'b0, rab_ack}, 8'h00);
    irq_src = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_check("rst_status", 3'd0, 8'h00);
    rd_check("rst_edge",   3'd2, 8'hFF);
    rd_check("rst_mask",   3'd1, 8'h00);
    rd_check("rst_id",     3'd5, 8'hFF);

    // Edge path
    wr_reg(3'd1, 8'h04);
    wr_reg(3'd6, 8'h01);
    rd_check("ctrl_rd", 3'd6, 8'h01);
    @(negedge clk); irq_src = 8'h04;
    @(posedge clk);
    @(negedge clk); irq_src = 8'h00;
    repeat (NS) @(posedge clk);
    #1 chk("edge_ex0_early", {7'b0, ex0}, 8'h00);
    @(posedge clk);
    #1 chk("edge_ex0_high", {7'b0, ex0}, 8'h01);
    rd_check("edge_status", 3'd0, 8'h04);
    rd_check("edge_id", 3'd5, 8'h02);
    wr_reg(3'd0, 8'h04);
    chk("edge_ex0_clr", {7'b0, ex0}, 8'h00);
    rd_check("edge_status_clr", 3'd0, 8'h00);

    // Level path
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd1, 8'h01);
    @(negedge clk); irq_src = 8'h01;
    repeat (5) @(negedge clk);
    rd_check("lvl_raw", 3'd3, 8'h01);
    wr_reg(3'd0, 8'h01);
    rd_check("lvl_status_reset", 3'd0, 8'h01);
    chk("lvl_ex0_stays", {7'b0, ex0}, 8'h01);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    wr_reg(3'd0, 8'h01);
    rd_check("lvl_status_clr", 3'd0, 8'h00);
    repeat (2) @(negedge clk);
    chk("lvl_ex0_low", {7'b0, ex0}, 8'h00);

    // Priority and software set
    wr_reg(3'd1, 8'hFF);
    wr_reg(3'd4, 8'hA0);
    rd_check("set_status", 3'd0, 8'hA0);
    rd_check("set_rd0", 3'd4, 8'h00);
    rd_check("set_id", 3'd5, 8'h05);
    wr_reg(3'd0, 8'h20);
    rd_check("set_id_next", 3'd5, 8'h07);
    wr_reg(3'd0, 8'h80);
    rd_check("set_status_clr", 3'd0, 8'h00);
    rd_check("rsvd_rd", 3'd7, 8'h00);

    // Handshake: held read, miss address, read+write collision
    @(negedge clk); rab_read = 1; rab_addr = ra(3'd3); acks = 0;
    repeat (6) begin @(posedge clk); #1; if (rab_ack) acks++; end
    @(negedge clk); rab_read = 0;
    chk("hold_ack_count", 8'(acks), 8'd1);
    repeat (3) @(negedge clk);
    rab_read = 1; rab_addr = {5'h4, 8'h00, 3'd1}; acks = 0;
    repeat (4) begin @(posedge clk); #1; if (rab_ack) acks++; end
    @(negedge clk); rab_read = 0;
    chk("miss_ack_count", 8'(acks), 8'd0);
    repeat (3) @(negedge clk);
    bus(1'b1, 1'b1, ra(3'd1), 8'h5A, d);
    chk("rw_rdata", d, 8'h00);
    rd_check("rw_mask", 3'd1, 8'h5A);

    // Set/clear collision on bit 1
    wr_reg(3'd2, 8'hFF);
    @(negedge clk); irq_src = 8'h02;
    repeat (NS) @(negedge clk);
    rab_write = 1; rab_addr = ra(3'd0); rab_wdata = 8'h02;
    @(posedge clk); #1;
    chk("coll_ack", {7'b0, rab_ack}, 8'h01);
    @(negedge clk); rab_write = 0;
    repeat (2) @(negedge clk);
    rd_check("coll_status", 3'd0, 8'h02);
    irq_src = 8'h00;
    wr_reg(3'd0, 8'h02);
    rd_check("coll_status_clr", 3'd0, 8'h00);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
